// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Arbitrates three register-file write sources onto a single write port using
// round-robin priority, with one registered output stage. Writes addressed to
// register 15 are accepted but dropped; they are tallied in a sticky error
// flag and a saturating drop counter.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   req_valid  per-requester write request (0 ALU, 1 memory load, 2 loader)
//   req_addr   per-requester destination register address
//   req_data   per-requester write data
//   req_ready  per-requester accept (combinational, at most one bit set)
//   hold       freezes arbitration for the current cycle
//   we3        register-file write enable (registered)
//   wa3        register-file write address (registered)
//   wd3        register-file write data (registered)
//   gnt_id     requester driving the write port, 2'b11 when idle
//   err_r15    sticky: an address-15 write was accepted and dropped
//   drop_cnt   saturating count of dropped address-15 writes
// -----------------------------------------------------------------------------
module regfile_wb_arbiter (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       req_valid,
   input  logic [2:0][3:0]  req_addr,
   input  logic [2:0][17:0] req_data,
   output logic [2:0]       req_ready,
   input  logic             hold,
   output logic             we3,
   output logic [3:0]       wa3,
   output logic [17:0]      wd3,
   output logic [1:0]       gnt_id,
   output logic             err_r15,
   output logic [7:0]       drop_cnt
);

   localparam logic [3:0] DROP_ADDR = 4'hF;
   localparam logic [1:0] IDLE_ID   = 2'b11;

   logic [1:0]  ptr_q,  ptr_d;
   logic        we3_q,  we3_d;
   logic [3:0]  wa3_q,  wa3_d;
   logic [17:0] wd3_q,  wd3_d;
   logic [1:0]  gnt_q,  gnt_d;
   logic        err_q,  err_d;
   logic [7:0]  cnt_q,  cnt_d;

   logic        gnt_valid;
   logic [1:0]  gnt_idx;
   logic [1:0]  scan_idx [3];

   // Scan order starting at the pointer, wrapped modulo 3. The pointer never
   // holds 3, so every scan position is a legal requester index.
   for (genvar gi = 0; gi < 3; gi++) begin : g_scan
      logic [2:0] scan_sum;
      assign scan_sum     = {1'b0, ptr_q} + 3'(gi);
      assign scan_idx[gi] = (scan_sum >= 3'd3) ? 2'(scan_sum - 3'd3) : scan_sum[1:0];
   end

   // First valid requester in scan order wins; reset and hold suppress all
   // grants so nothing is consumed while either is asserted.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = 2'd0;
      req_ready = 3'b000;
      if (!reset && !hold) begin
         for (int k = 0; k < 3; k++) begin
            if (!gnt_valid && req_valid[scan_idx[k]]) begin
               gnt_valid = 1'b1;
               gnt_idx   = scan_idx[k];
            end
         end
      end
      if (gnt_valid) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // Next state of the output stage. Address/data hold their last values on
   // idle and dropped cycles so the register file sees a quiet bus.
   always_comb begin
      ptr_d = ptr_q;
      we3_d = 1'b0;
      wa3_d = wa3_q;
      wd3_d = wd3_q;
      gnt_d = IDLE_ID;
      err_d = err_q;
      cnt_d = cnt_q;
      if (gnt_valid) begin
         // A dropped write still advances the pointer.
         ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
         if (req_addr[gnt_idx] == DROP_ADDR) begin
            err_d = 1'b1;
            if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end else begin
            we3_d = 1'b1;
            wa3_d = req_addr[gnt_idx];
            wd3_d = req_data[gnt_idx];
            gnt_d = gnt_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 2'd0;
         we3_q <= 1'b0;
         wa3_q <= 4'h0;
         wd3_q <= 18'h0;
         gnt_q <= IDLE_ID;
         err_q <= 1'b0;
         cnt_q <= 8'h00;
      end else begin
         ptr_q <= ptr_d;
         we3_q <= we3_d;
         wa3_q <= wa3_d;
         wd3_q <= wd3_d;
         gnt_q <= gnt_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign we3      = we3_q;
   assign wa3      = wa3_q;
   assign wd3      = wd3_q;
   assign gnt_id   = gnt_q;
   assign err_r15  = err_q;
   assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_wb_arbiter. A reference model predicts req_ready in
// the current cycle and the registered outputs of the next cycle; predictions
// are pushed to a scoreboard queue and popped after the following edge.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       req_valid;
   logic [2:0][3:0]  req_addr;
   logic [2:0][17:0] req_data;
   logic [2:0]       req_ready;
   logic             hold;
   logic             we3;
   logic [3:0]       wa3;
   logic [17:0]      wd3;
   logic [1:0]       gnt_id;
   logic             err_r15;
   logic [7:0]       drop_cnt;

   regfile_wb_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .hold      (hold),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .gnt_id    (gnt_id),
      .err_r15   (err_r15),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [17:0] wd;
      logic [1:0]  gnt;
      logic        err;
      logic [7:0]  cnt;
   } exp_t;

   exp_t sb_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          m_ptr = 0;
   logic [3:0]  m_wa  = 4'h0;
   logic [17:0] m_wd  = 18'h0;
   logic        m_err = 1'b0;
   logic [7:0]  m_cnt = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock cycle: inputs are already driven. Predict, check ready,
   // push expectation, advance one edge, pop and compare registered outputs.
   task automatic run_cycle();
      int   g;
      logic [2:0] exp_rdy;
      exp_t e;
      exp_t o;
      #1;
      g = -1;
      exp_rdy = 3'b000;
      if (!reset && !hold) begin
         for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (m_ptr + k) % 3;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_eq("ready", 32'(req_ready), 32'(exp_rdy));

      if (reset) begin
         m_ptr = 0; m_wa = 4'h0; m_wd = 18'h0; m_err = 1'b0; m_cnt = 8'h00;
         e.we = 1'b0; e.gnt = 2'b11;
      end else if (g >= 0) begin
         m_ptr = (g + 1) % 3;
         if (req_addr[g] == 4'hF) begin
            m_err = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            e.we = 1'b0; e.gnt = 2'b11;
         end else begin
            m_wa = req_addr[g];
            m_wd = req_data[g];
            e.we = 1'b1; e.gnt = 2'(g);
         end
      end else begin
         e.we = 1'b0; e.gnt = 2'b11;
      end
      e.wa = m_wa; e.wd = m_wd; e.err = m_err; e.cnt = m_cnt;
      sb_q.push_back(e);

      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
         o = sb_q.pop_front();
         check_eq("we3",      32'(we3),      32'(o.we));
         check_eq("wa3",      32'(wa3),      32'(o.wa));
         check_eq("wd3",      32'(wd3),      32'(o.wd));
         check_eq("gnt_id",   32'(gnt_id),   32'(o.gnt));
         check_eq("err_r15",  32'(err_r15),  32'(o.err));
         check_eq("drop_cnt", 32'(drop_cnt), 32'(o.cnt));
         $display("cyc t=%0t rst=%0b hold=%0b valid=%03b ready=%03b we3=%0b wa3=%0h wd3=%05h gnt=%0d err=%0b cnt=%0d",
                  $time, reset, hold, req_valid, req_ready, we3, wa3, wd3, gnt_id, err_r15, drop_cnt);
      end
   endtask

   task automatic drive(input logic rst, input logic hld, input logic [2:0] v,
                        input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                        input logic [17:0] d0, input logic [17:0] d1, input logic [17:0] d2);
      reset       = rst;
      hold        = hld;
      req_valid   = v;
      req_addr[0] = a0; req_addr[1] = a1; req_addr[2] = a2;
      req_data[0] = d0; req_data[1] = d1; req_data[2] = d2;
   endtask

   initial begin
      drive(1'b1, 1'b0, 3'b111, 4'd1, 4'd2, 4'd3, 18'h1, 18'h2, 18'h3);

      // Reset with requests present: nothing accepted, outputs at reset values
      run_cycle();
      run_cycle();
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_gnt",   32'(gnt_id),    32'd3);

      // Three requesters continuously valid: grants 0,1,2 in order
      drive(1'b0, 1'b0, 3'b111, 4'd1, 4'd2, 4'd3, 18'h00A, 18'h00B, 18'h00C);
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         check_eq("rr_gnt", 32'(gnt_id), 32'(i));
         check_eq("rr_wa3", 32'(wa3),    32'(i + 1));
      end

      // Idle cycle: write port quiet, address/data held
      drive(1'b0, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 18'h0, 18'h0, 18'h0);
      run_cycle();
      check_eq("idle_wa3", 32'(wa3), 32'd3);

      // Single requester 1, max data
      drive(1'b0, 1'b0, 3'b010, 4'd0, 4'd5, 4'd0, 18'h0, 18'h3FFFF, 18'h0);
      run_cycle();
      check_eq("r1_wd3", 32'(wd3),    32'h3FFFF);
      check_eq("r1_gnt", 32'(gnt_id), 32'd1);

      // Address-15 writes are dropped; the counter saturates at 255
      drive(1'b0, 1'b0, 3'b001, 4'd15, 4'd0, 4'd0, 18'h1234, 18'h0, 18'h0);
      run_cycle();
      check_eq("drop1_cnt", 32'(drop_cnt), 32'd1);
      check_eq("drop1_we3", 32'(we3),      32'd0);
      for (int i = 0; i < 299; i++) run_cycle();
      check_eq("drop_sat", 32'(drop_cnt), 32'd255);

      // Hold freezes arbitration; release resumes from the pre-hold pointer (1)
      drive(1'b0, 1'b1, 3'b111, 4'd4, 4'd6, 4'd8, 18'h11, 18'h22, 18'h33);
      for (int i = 0; i < 4; i++) run_cycle();
      hold = 1'b0;
      run_cycle();
      check_eq("hold_rel_gnt", 32'(gnt_id), 32'd1);

      // Randomised traffic including occasional hold and reset
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
               3'($urandom_range(0, 7)),
               4'($urandom), 4'($urandom), 4'($urandom),
               18'($urandom), 18'($urandom), 18'($urandom));
         run_cycle();
      end

      // Accept a write to address 7, then reset on the next edge
      drive(1'b0, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 18'h0, 18'h0, 18'h0);
      run_cycle();
      drive(1'b0, 1'b0, 3'b100, 4'd0, 4'd0, 4'd7, 18'h0, 18'h0, 18'h777);
      run_cycle();
      drive(1'b1, 1'b0, 3'b111, 4'd1, 4'd2, 4'd3, 18'h5, 18'h6, 18'h7);
      run_cycle();
      check_eq("rst_we3", 32'(we3),      32'd0);
      check_eq("rst_err", 32'(err_r15),  32'd0);
      check_eq("rst_cnt", 32'(drop_cnt), 32'd0);
      reset = 1'b0;
      run_cycle();
      check_eq("post_rst_gnt", 32'(gnt_id), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: none; all widths are fixed (4-bit register address, 18-bit data, 3 requesters).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  3  per-requester write request (bit0 ALU writeback, bit1 memory load, bit2 external loader).
REQ-005 req_addr  input  3x4  per-requester destination register address.
REQ-006 req_data  input  3x18  per-requester write data.
REQ-007 req_ready  output  3  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-008 hold  input  1  when 1, freezes arbitration (no grants) for that cycle.
REQ-009 we3  output  1  register-file write enable.
REQ-010 wa3  output  4  register-file write address.
REQ-011 wd3  output  18  register-file write data.
REQ-012 gnt_id  output  2  index of requester whose write is on we3/wa3/wd3; 2'b11 when we3=0.
REQ-013 err_r15  output  1  sticky flag: a write to address 15 was accepted and dropped.
REQ-014 drop_cnt  output  8  saturating count of dropped address-15 writes.

Function
REQ-015 At most one req_ready bit shall be 1 per cycle; req_ready is combinational from req_valid, hold and the round-robin pointer.
REQ-016 req_ready[i] shall be 1 only if req_valid[i]=1, hold=0 and i is the first valid requester found scanning upward (mod 3) from the round-robin pointer.
REQ-017 Round-robin pointer: 2-bit, values 0..2; after a grant to requester i it shall become (i+1) mod 3; unchanged when no grant; never holds 3.
REQ-018 If hold=1, all req_ready shall be 0 and the pointer unchanged, regardless of req_valid.
REQ-019 An accepted write with address 0..14 shall appear on we3=1, wa3, wd3, gnt_id exactly one cycle after acceptance (registered outputs, latency 1).
REQ-020 In any cycle following no acceptance, we3 shall be 0, gnt_id 2'b11; wa3/wd3 shall hold their previous values.
REQ-021 An accepted write with address 15 shall be consumed (ready=1) but shall not assert we3 the following cycle; err_r15 shall set to 1 and drop_cnt shall increment by 1.
REQ-022 drop_cnt shall saturate at 255; err_r15 shall stay 1 until reset.
REQ-023 A dropped address-15 write still counts as a grant for pointer advancement.
REQ-024 Output registers update on rising edge; the register file samples on falling edge, so we3/wa3/wd3 shall be stable for the full cycle and never glitch after the rising edge.
REQ-025 Requesters not granted shall keep their request pending; the block shall not store any request beyond the single output stage.
REQ-026 A requester continuously valid shall be granted within 3 cycles of hold=0 cycles (starvation bound).

Reset
REQ-027 While reset=1: req_ready=3'b000, we3=0, wa3=4'h0, wd3=18'h0, gnt_id=2'b11, err_r15=0, drop_cnt=8'h00, pointer=0.
REQ-028 Reset asserted mid-operation shall discard any write in the output stage (we3=0 on the cycle after reset sampled) and any request presented that cycle shall not be accepted.
REQ-029 First cycle after reset deasserts, arbitration starts from requester 0.

Verification
REQ-030 After reset, req_valid=3'b111, addrs 1/2/3, data 18'h00A/18'h00B/18'h00C, hold=0 for 3 cycles -> grants 0,1,2 in order; we3=1 with wa3=1,2,3 on cycles 2,3,4; gnt_id=0,1,2.
REQ-031 req_valid=3'b010 only, addr 5, data 18'h3FFFF -> req_ready=3'b010 same cycle; next cycle we3=1, wa3=5, wd3=18'h3FFFF, gnt_id=1; pointer=2.
REQ-032 req_valid=3'b001, addr 15, data 18'h1234 -> ready=1, next cycle we3=0, gnt_id=2'b11, err_r15=1, drop_cnt=1; 300 such writes -> drop_cnt=255.
REQ-033 req_valid=3'b111 with hold=1 for 4 cycles -> req_ready=0 and we3=0 throughout; on hold=0 the grant goes to the pre-hold pointer value.
REQ-034 Accept write to addr 7 then assert reset the next edge -> we3=0 after reset, err_r15=0, drop_cnt=0, next grant goes to requester 0.
